// File: rtl/pll_seq_pkg.sv
// Shared types and helpers for the PLL reset sequencer.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4
  } state_t;

  localparam int unsigned LOSS_CNT_W = 8;

  // Bits needed for a counter that must reach max_val (never narrower than 1).
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; async reset clears to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Two-stage capture to let metastability resolve before use.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL supervisor: pulses PLL reset, waits for stable lock, releases domain
// resets in index order, and re-sequences on lock loss, timeout or sw request.
// Optional macro LOCK_LOSS_CNT_EN enables the saturating lock-loss counter.
// rst_dom is refclk-registered; consumers re-synchronize its deassertion.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned RST_PULSE_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 50000,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned NUM_DOMAINS         = 3,
  parameter int unsigned STAGGER_CYCLES      = 64
) (
  input  logic                   refclk,
  input  logic                   rst,
  input  logic                   pll_locked,
  input  logic                   sw_rst_req,
  output logic                   pll_rst,
  output logic [NUM_DOMAINS-1:0] rst_dom,
  output logic                   ready,
  output logic                   lock_lost,
  output logic [LOSS_CNT_W-1:0]  lock_loss_cnt
);

  localparam int unsigned PW = cnt_w(RST_PULSE_CYCLES);
  localparam int unsigned TW = cnt_w(LOCK_TIMEOUT_CYCLES);
  localparam int unsigned SW = cnt_w(LOCK_STABLE_CYCLES);
  localparam int unsigned GW = cnt_w(STAGGER_CYCLES);
  localparam int unsigned DW = cnt_w(NUM_DOMAINS);

  state_t                 state, state_n;
  logic [PW-1:0]          pulse_cnt, pulse_n;
  logic [TW-1:0]          tmo_cnt, tmo_n;
  logic [SW-1:0]          stab_cnt, stab_n;
  logic [GW-1:0]          stag_cnt, stag_n;
  logic [DW-1:0]          dom_idx, dom_n;
  logic                   lost_n;
  logic                   rel_n;
  logic [NUM_DOMAINS-1:0] rst_dom_n;
  logic                   lock_s;

  sync_2ff u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d   (pll_locked),
    .q   (lock_s)
  );

  // State, counters and registered outputs.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state     <= PLL_RST;
      pulse_cnt <= '0;
      tmo_cnt   <= '0;
      stab_cnt  <= '0;
      stag_cnt  <= '0;
      dom_idx   <= '0;
      pll_rst   <= 1'b1;
      rst_dom   <= '1;
      ready     <= 1'b0;
      lock_lost <= 1'b0;
    end else begin
      state     <= state_n;
      pulse_cnt <= pulse_n;
      tmo_cnt   <= tmo_n;
      stab_cnt  <= stab_n;
      stag_cnt  <= stag_n;
      dom_idx   <= dom_n;
      pll_rst   <= (state_n == PLL_RST);
      rst_dom   <= rst_dom_n;
      ready     <= (state_n == RUN);
      lock_lost <= lost_n;
    end
  end

  // Next-state and counter update; sw request overrides everything last.
  always_comb begin
    state_n = state;
    pulse_n = pulse_cnt;
    tmo_n   = tmo_cnt;
    stab_n  = stab_cnt;
    stag_n  = stag_cnt;
    dom_n   = dom_idx;
    lost_n  = 1'b0;

    case (state)
      PLL_RST: begin
        if (pulse_cnt == PW'(RST_PULSE_CYCLES - 1)) begin
          state_n = WAIT_LOCK;
          tmo_n   = '0;
        end else begin
          pulse_n = pulse_cnt + PW'(1);
        end
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          state_n = STABLE;
          stab_n  = '0;
        end else if (tmo_cnt == TW'(LOCK_TIMEOUT_CYCLES - 1)) begin
          state_n = PLL_RST;
          pulse_n = '0;
        end else begin
          tmo_n = tmo_cnt + TW'(1);
        end
      end
      STABLE: begin
        if (!lock_s) begin
          state_n = WAIT_LOCK;
          tmo_n   = '0;
        end else if (stab_cnt == SW'(LOCK_STABLE_CYCLES - 1)) begin
          state_n = RELEASE;
          dom_n   = '0;
          stag_n  = '0;
        end else begin
          stab_n = stab_cnt + SW'(1);
        end
      end
      RELEASE: begin
        if (!lock_s) begin
          state_n = PLL_RST;
          pulse_n = '0;
          lost_n  = 1'b1;
        end else if (dom_idx == DW'(NUM_DOMAINS - 1)) begin
          state_n = RUN;
        end else if (stag_cnt == GW'(STAGGER_CYCLES - 1)) begin
          stag_n = '0;
          dom_n  = dom_idx + DW'(1);
        end else begin
          stag_n = stag_cnt + GW'(1);
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_n = PLL_RST;
          pulse_n = '0;
          lost_n  = 1'b1;
        end
      end
      default: begin
        state_n = PLL_RST;
        pulse_n = '0;
      end
    endcase

    if (sw_rst_req) begin
      state_n = PLL_RST;
      pulse_n = '0;
      tmo_n   = '0;
      stab_n  = '0;
      stag_n  = '0;
      dom_n   = '0;
    end
  end

  // Domains up to dom_idx are released; lower indices always go first.
  always_comb begin
    rst_dom_n = '1;
    rel_n     = (state_n == RELEASE) || (state_n == RUN);
    for (int unsigned i = 0; i < NUM_DOMAINS; i++) begin
      rst_dom_n[i] = !(rel_n && (DW'(i) <= dom_n));
    end
  end

`ifdef LOCK_LOSS_CNT_EN
  logic [LOSS_CNT_W-1:0] loss_cnt_q;

  // Saturating lock-loss counter; survives sw restarts, cleared only by rst.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      loss_cnt_q <= '0;
    end else if (lost_n && (loss_cnt_q != '1)) begin
      loss_cnt_q <= loss_cnt_q + LOSS_CNT_W'(1);
    end
  end

  assign lock_loss_cnt = loss_cnt_q;
`else
  assign lock_loss_cnt = '0;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with a cycle-stamped expectation queue.
module tb_pll_reset_sequencer;

  localparam int unsigned ND = 3;

  logic          refclk = 1'b0;
  logic          rst;
  logic          pll_locked;
  logic          sw_rst_req;
  logic          pll_rst;
  logic [ND-1:0] rst_dom;
  logic          ready;
  logic          lock_lost;
  logic [7:0]    lock_loss_cnt;

  typedef struct {
    int         cyc;
    string      tag;
    logic [5:0] val;   // {rst_dom[2:0], pll_rst, ready, lock_lost}
  } exp_t;

  exp_t       q[$];
  int         cyc    = 0;
  int         base   = 0;
  int         tnum   = 0;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_llc;

  pll_reset_sequencer #(
    .RST_PULSE_CYCLES    (4),
    .LOCK_TIMEOUT_CYCLES (32),
    .LOCK_STABLE_CYCLES  (8),
    .NUM_DOMAINS         (ND),
    .STAGGER_CYCLES      (2)
  ) dut (
    .refclk        (refclk),
    .rst           (rst),
    .pll_locked    (pll_locked),
    .sw_rst_req    (sw_rst_req),
    .pll_rst       (pll_rst),
    .rst_dom       (rst_dom),
    .ready         (ready),
    .lock_lost     (lock_lost),
    .lock_loss_cnt (lock_loss_cnt)
  );

  always #5 refclk = ~refclk;

  task automatic push(input int k, input logic [5:0] v);
    exp_t e;
    e.cyc = base + k;
    e.tag = $sformatf("t%0d_k%0d", tnum, k);
    e.val = v;
    q.push_back(e);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one cycle, sample on the falling edge and retire due expectations.
  task automatic tick();
    @(negedge refclk);
    cyc++;
    while (q.size() != 0 && q[0].cyc <= cyc) begin
      exp_t       e;
      logic [5:0] obs;
      e   = q.pop_front();
      obs = {rst_dom, pll_rst, ready, lock_lost};
      checks++;
      assert (e.cyc == cyc && obs === e.val) else begin
        errors++;
        $error("FAIL %s cyc=%0d observed=%b expected=%b", e.tag, cyc, obs, e.val);
      end
    end
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    checks++;
    assert (q.size() == 0) else begin
      errors++;
      $error("FAIL timeout_t%0d observed=%0d_pending expected=0_pending", tnum, q.size());
      q.delete();
    end
  endtask

  initial begin
`ifdef LOCK_LOSS_CNT_EN
    exp_llc = 8'd1;
`else
    exp_llc = 8'd0;
`endif
    rst        = 1'b1;
    pll_locked = 1'b0;
    sw_rst_req = 1'b0;
    repeat (3) tick();

    // Reset values.
    chk("rst_pll_rst", 8'(pll_rst), 8'd1);
    chk("rst_dom",     8'(rst_dom), 8'h07);
    chk("rst_ready",   8'(ready), 8'd0);
    chk("rst_lost",    8'(lock_lost), 8'd0);
    chk("rst_llc",     lock_loss_cnt, 8'd0);

    // 1: power-up; lock at cycle 10 -> lock_s at 12, STABLE 13..20, release at 21.
    tnum = 1; base = cyc;
    push(1,  6'b111_1_0_0);
    push(3,  6'b111_1_0_0);
    push(4,  6'b111_0_0_0);
    push(20, 6'b111_0_0_0);
    push(21, 6'b110_0_0_0);
    push(22, 6'b110_0_0_0);
    push(23, 6'b100_0_0_0);
    push(24, 6'b100_0_0_0);
    push(25, 6'b000_0_0_0);
    push(26, 6'b000_0_1_0);
    rst = 1'b0;
    wait_to(base + 10);
    pll_locked = 1'b1;
    drain(40);

    // 4+2: lock drop in RUN, then lock held low -> PLL reset re-pulses every 36.
    tnum = 4; base = cyc;
    push(2,  6'b000_0_1_0);
    push(3,  6'b111_1_0_1);
    push(4,  6'b111_1_0_0);
    push(6,  6'b111_1_0_0);
    push(7,  6'b111_0_0_0);
    push(38, 6'b111_0_0_0);
    push(39, 6'b111_1_0_0);
    push(42, 6'b111_1_0_0);
    push(43, 6'b111_0_0_0);
    pll_locked = 1'b0;
    wait_to(base + 3);
    chk("t4_llc", lock_loss_cnt, exp_llc);
    drain(60);

    // 3: one-cycle lock glitch at STABLE count 5 forces a full recount.
    tnum = 3; base = cyc;
    push(9,  6'b111_0_0_0);
    push(11, 6'b111_0_0_0);
    push(17, 6'b111_0_0_0);
    push(18, 6'b110_0_0_0);
    push(20, 6'b100_0_0_0);
    push(22, 6'b000_0_0_0);
    push(23, 6'b000_0_1_0);
    pll_locked = 1'b1;
    wait_to(base + 6);
    pll_locked = 1'b0;
    wait_to(base + 7);
    pll_locked = 1'b1;
    drain(40);

    // 5: sw restart from RUN, again mid-RELEASE, and once more inside PLL_RST.
    tnum = 5; base = cyc;
    push(1,  6'b111_1_0_0);
    push(4,  6'b111_1_0_0);
    push(5,  6'b111_0_0_0);
    push(13, 6'b111_0_0_0);
    push(14, 6'b110_0_0_0);
    push(15, 6'b110_0_0_0);
    push(16, 6'b111_1_0_0);
    push(17, 6'b111_1_0_0);
    push(20, 6'b111_1_0_0);
    push(21, 6'b111_1_0_0);
    push(22, 6'b111_0_0_0);
    push(30, 6'b111_0_0_0);
    push(31, 6'b110_0_0_0);
    push(33, 6'b100_0_0_0);
    push(35, 6'b000_0_0_0);
    push(36, 6'b000_0_1_0);
    sw_rst_req = 1'b1;
    wait_to(base + 1);
    sw_rst_req = 1'b0;
    wait_to(base + 15);
    sw_rst_req = 1'b1;
    wait_to(base + 16);
    sw_rst_req = 1'b0;
    wait_to(base + 17);
    sw_rst_req = 1'b1;
    wait_to(base + 18);
    sw_rst_req = 1'b0;
    drain(40);
    chk("t5_llc", lock_loss_cnt, exp_llc);

    // 6: async reset between clock edges while in RUN.
    tnum = 6;
    #2;
    rst = 1'b1;
    #1;
    chk("t6_pll_rst", 8'(pll_rst), 8'd1);
    chk("t6_dom",     8'(rst_dom), 8'h07);
    chk("t6_ready",   8'(ready), 8'd0);
    chk("t6_lost",    8'(lock_lost), 8'd0);
    chk("t6_llc",     lock_loss_cnt, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
